jtframe_mister_ddrwr: RTL and testbench

JTFRAME_MISTER_DDRWR -- requirements
Module: jtframe_mister_ddrwr

---
 rtl/jtframe_mister_ddrwr_pkg.sv | 28 ++
 rtl/jtframe_mister_ddrwr_if.sv | 22 ++
 rtl/jtframe_rpwp_ram.sv | 23 ++
 rtl/jtframe_mister_ddrwr.sv | 234 +++++++++++++++++++++++
 tb/tb_jtframe_mister_ddrwr.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_mister_ddrwr_pkg.sv
// Constants shared by the MiSTer DDRAM dump writer and its matching reader.
package jtframe_mister_ddrwr_pkg;

    // Avalon DDRAM port geometry: word address, 64-bit data, 8-bit burst count
    localparam int DDR_AW  = 29;
    localparam int DDR_DW  = 64;
    localparam int DDR_BCW = 8;

    // Default region: address bits [28:25] = 3, i.e. byte address 0x3000_0000
    // (word address 0x0600_0000).
    localparam logic [3:0] DDR_BASE = 4'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_STORE = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    // Byte enables for a word holding n bytes starting at lane 0; n==0 means 8.
    function automatic logic [7:0] lane_mask(input logic [2:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (n == 3'd0) || (i < int'(n));
        return m;
    endfunction

endpackage

// File: rtl/jtframe_mister_ddrwr_if.sv
// Avalon-MM write side of the MiSTer DDRAM port.
interface jtframe_mister_ddrwr_if;
    import jtframe_mister_ddrwr_pkg::*;

    logic                ddram_busy;
    logic                ddram_we;
    logic [DDR_AW-1:0]   ddram_addr;
    logic [DDR_BCW-1:0]  ddram_burstcnt;
    logic [DDR_DW-1:0]   ddram_din;
    logic [7:0]          ddram_be;

    modport master (
        input  ddram_busy,
        output ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be
    );

    modport slave (
        output ddram_busy,
        input  ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be
    );

endinterface

// File: rtl/jtframe_rpwp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module jtframe_rpwp_ram #(
    parameter int DW = 64,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write port plus registered read; q holds its value while re is low
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
        if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/jtframe_mister_ddrwr.sv
// Dumps len bytes read from the core into DDRAM, packing bytes into 64-bit
// words and writing them in bursts of up to 2^BW words, one page per burst.
module jtframe_mister_ddrwr
    import jtframe_mister_ddrwr_pkg::*;
#(
    parameter int         BW   = 7,
    parameter logic [3:0] BASE = DDR_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] len,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [26:0] rd_addr,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    jtframe_mister_ddrwr_if.master ddr
);

    localparam int          PW    = DDR_AW - 4 - BW;
    localparam logic [BW:0] WFULL = (BW+1)'(1) << BW;

    state_t           state_q, state_d;
    logic [26:0]      len_q, len_d;
    logic [26:0]      cnt_q, cnt_d;
    logic [BW:0]      wcnt_q, wcnt_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [PW-1:0]    page_q, page_d;
    logic [63:0]      word_q, word_d;
    logic [7:0]       last_be_q, last_be_d;
    logic [5:0]       tmo_q, tmo_d;
    logic             pre_q, pre_d;
    logic             rd_req_q, rd_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_err_q, tmo_err_d;
    logic             we_q, we_d;
    logic [63:0]      din_q, din_d;
    logic [7:0]       be_q, be_d;

    logic             ram_we, ram_re;
    logic [BW-1:0]    ram_raddr;
    logic [63:0]      ram_q;

    logic             take, last_byte, all_done, last_beat, accept;
    logic [7:0]       byte_in;

    // A byte is taken on ack, or forced to FF once the read has waited 63 cycles
    assign take      = rd_req_q & (rd_ack | (tmo_q == 6'h3F));
    assign byte_in   = rd_ack ? rd_data : 8'hFF;
    assign last_byte = (cnt_q + 27'd1) == len_q;
    assign all_done  = cnt_q == len_q;
    assign last_beat = {1'b0, beat_q} == (wcnt_q - 1'b1);
    assign accept    = we_q & ~ddr.ddram_busy;

    // Next-state logic for the fetch/pack/burst sequence
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        beat_d    = beat_q;
        page_d    = page_q;
        word_d    = word_q;
        last_be_d = last_be_q;
        tmo_d     = tmo_q;
        pre_d     = pre_q;
        rd_req_d  = rd_req_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmo_err_d = tmo_err_q;
        we_d      = we_q;
        din_d     = din_q;
        be_d      = be_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = len;
                    cnt_d     = '0;
                    wcnt_d    = '0;
                    page_d    = '0;
                    tmo_d     = '0;
                    tmo_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = (len == 27'd0) ? ST_FIN : ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (!rd_req_q) begin
                    // request low for one cycle after each byte, then re-raise
                    rd_req_d = 1'b1;
                    tmo_d    = '0;
                end else if (take) begin
                    word_d[{cnt_q[2:0], 3'b000} +: 8] = byte_in;
                    cnt_d    = cnt_q + 27'd1;
                    rd_req_d = 1'b0;
                    tmo_d    = '0;
                    if (!rd_ack) tmo_err_d = 1'b1;
                    if (cnt_q[2:0] == 3'd7 || last_byte) state_d = ST_STORE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_STORE: begin
                ram_we    = 1'b1;
                wcnt_d    = wcnt_q + 1'b1;
                // only the final word of a dump can be partial, and it is
                // always the final beat of its burst
                last_be_d = lane_mask(cnt_q[2:0]);
                if ((wcnt_q + 1'b1) == WFULL || all_done) begin
                    state_d = ST_WRITE;
                    beat_d  = '0;
                    pre_d   = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_WRITE: begin
                if (!we_q) begin
                    // two-cycle preload: word 0 into din, word 1 into ram_q
                    ram_re = 1'b1;
                    if (!pre_q) begin
                        ram_raddr = '0;
                        pre_d     = 1'b1;
                    end else begin
                        ram_raddr = BW'(1);
                        we_d      = 1'b1;
                        din_d     = ram_q;
                        be_d      = (wcnt_q == (BW+1)'(1)) ? last_be_q : 8'hFF;
                    end
                end else if (accept) begin
                    if (last_beat) begin
                        we_d    = 1'b0;
                        page_d  = page_q + 1'b1;
                        wcnt_d  = '0;
                        state_d = all_done ? ST_FIN : ST_FETCH;
                    end else begin
                        // ram_q already holds the next word; fetch the one after
                        beat_d    = beat_q + 1'b1;
                        din_d     = ram_q;
                        be_d      = (({1'b0, beat_q} + (BW+1)'(2)) == wcnt_q) ? last_be_q : 8'hFF;
                        ram_re    = 1'b1;
                        ram_raddr = beat_q + BW'(2);
                    end
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; any burst in flight is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            beat_q    <= '0;
            page_q    <= '0;
            word_q    <= '0;
            last_be_q <= '0;
            tmo_q     <= '0;
            pre_q     <= 1'b0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            we_q      <= 1'b0;
            din_q     <= '0;
            be_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            beat_q    <= beat_d;
            page_q    <= page_d;
            word_q    <= word_d;
            last_be_q <= last_be_d;
            tmo_q     <= tmo_d;
            pre_q     <= pre_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
            we_q      <= we_d;
            din_q     <= din_d;
            be_q      <= be_d;
        end
    end

    jtframe_rpwp_ram #(
        .DW (DDR_DW),
        .AW (BW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wcnt_q[BW-1:0]),
        .din   (word_q),
        .re    (ram_re),
        .raddr (ram_raddr),
        .q     (ram_q)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_err_q;
    assign rd_addr     = cnt_q;
    assign rd_req      = rd_req_q;

    assign ddr.ddram_we       = we_q;
    assign ddr.ddram_addr     = {BASE, page_q, {BW{1'b0}}};
    assign ddr.ddram_burstcnt = DDR_BCW'(wcnt_q);
    assign ddr.ddram_din      = din_q;
    assign ddr.ddram_be       = be_q;

endmodule

// File: tb/tb_jtframe_mister_ddrwr.sv
// Scoreboard bench: a byte-level model predicts every DDRAM beat of a dump;
// a monitor compares each presented beat against the queue head.
module tb_jtframe_mister_ddrwr;
    import jtframe_mister_ddrwr_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [26:0] len;
    logic        busy, done, timeout_err;
    logic [26:0] rd_addr;
    logic        rd_req, rd_ack;
    logic [7:0]  rd_data;

    jtframe_mister_ddrwr_if ddr();

    jtframe_mister_ddrwr #(.BW(7), .BASE(4'd3)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .ddr(ddr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [28:0] addr;
        logic [7:0]  bc;
        logic [63:0] din;
        logic [7:0]  be;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    logic [63:0] mon_m;

    int checks = 0, errors = 0;
    int salt = 0, miss = -1, ack_dly = 0, stall_pct = 0;
    bit tgt_stall = 0;
    int acc_cnt = 0, beat_in_burst = 0, burst_no = 0, done_cnt = 0;
    int stall_left = 0, last_key = -1;
    int wait_cnt = 0;
    bit acked = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Model: byte i of the dump lands in word i/8, lane i%8; bursts of up
    // to 128 words, page p of the dump at word address (3<<25) + p*128.
    task automatic push_expected(input int L);
        int nwords = (L + 7) / 8;
        int w = 0;
        int page = 0;
        while (w < nwords) begin
            int nb = (nwords - w > 128) ? 128 : nwords - w;
            for (int k = 0; k < nb; k++) begin
                beat_t b;
                int idx = w + k;
                int n = L - 8 * idx;
                if (n > 8) n = 8;
                b.addr = 29'((3 << 25) + page * 128);
                b.bc   = 8'(nb);
                b.be   = 8'((1 << n) - 1);
                b.din  = '0;
                for (int j = 0; j < n; j++) begin
                    int a = 8 * idx + j;
                    b.din[8*j +: 8] = (a == miss) ? 8'hFF : 8'(a ^ salt);
                end
                exp_q.push_back(b);
            end
            w += nb;
            page++;
        end
    endtask

    // Core side: ack each request after ack_dly cycles; address 'miss' is never acked
    initial begin
        rd_ack = 1'b0; rd_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            rd_ack = 1'b0;
            if (!rd_req) begin
                acked = 0; wait_cnt = 0;
            end else if (!acked) begin
                if (wait_cnt >= ack_dly && int'(rd_addr) != miss) begin
                    rd_ack  = 1'b1;
                    rd_data = rd_addr[7:0] ^ 8'(salt);
                    acked   = 1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // DDRAM waitrequest: random stalls, plus 5-cycle stalls on beats 0 and 63
    initial begin
        ddr.ddram_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                ddr.ddram_busy = 1'b1;
                stall_left--;
            end else if (tgt_stall && ddr.ddram_we && (beat_in_burst == 0 || beat_in_burst == 63)
                         && (burst_no * 256 + beat_in_burst) != last_key) begin
                last_key = burst_no * 256 + beat_in_burst;
                ddr.ddram_busy = 1'b1;
                stall_left = 4;
            end else begin
                ddr.ddram_busy = int'($urandom_range(99)) < stall_pct;
            end
        end
    end

    // Monitor: every presented beat must equal the queue head; pop on accept
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (ddr.ddram_we) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got addr %h din %h, no beat expected",
                                 ddr.ddram_addr, ddr.ddram_din);
                    end else begin
                        mon_e = exp_q[0];
                        for (int i = 0; i < 8; i++) mon_m[8*i +: 8] = {8{ddr.ddram_be[i]}};
                        checks++;
                        if (ddr.ddram_addr !== mon_e.addr || ddr.ddram_burstcnt !== mon_e.bc ||
                            ddr.ddram_be !== mon_e.be || (ddr.ddram_din & mon_m) !== mon_e.din) begin
                            errors++;
                            $display("FAIL %s #%0d: got addr %h bc %0d be %h din %h expected addr %h bc %0d be %h din %h",
                                     ddr.ddram_busy ? "stall_hold" : "beat", acc_cnt,
                                     ddr.ddram_addr, ddr.ddram_burstcnt, ddr.ddram_be, ddr.ddram_din & mon_m,
                                     mon_e.addr, mon_e.bc, mon_e.be, mon_e.din);
                        end
                        if (!ddr.ddram_busy) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                            beat_in_burst++;
                            if (beat_in_burst == int'(mon_e.bc)) begin
                                beat_in_burst = 0;
                                burst_no++;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic start_pulse(input int L);
        len = 27'(L); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fin_dump(input string nm, input int L, input bit exp_tmo, input int d0);
        bit ok = 0;
        for (int i = 0; i < L * 90 + 3000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: got no done expected done", nm);
        end
        tick();
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_timeout_err"}, timeout_err, exp_tmo);
        chk({nm, "_busy_after"}, busy, 0);
        exp_q.delete();
    endtask

    task automatic run_dump(input string nm, input int L, input bit exp_tmo);
        int d0 = done_cnt;
        acc_cnt = 0; beat_in_burst = 0; burst_no = 0; last_key = -1;
        push_expected(L);
        start_pulse(L);
        fin_dump(nm, L, exp_tmo, d0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        int bl[6] = '{1, 7, 8, 9, 1024, 1032};
        rst = 1'b1; start = 1'b0; len = '0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_we", ddr.ddram_we, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_be", ddr.ddram_be, 8'h00);
        rst = 1'b0;
        tick(2);

        // two full words in one burst
        ack_dly = 2; stall_pct = 0; salt = 0;
        run_dump("len16", 16, 0);

        // full 128-word burst then 1-word partial burst, stalls on beats 0/63
        ack_dly = 1; tgt_stall = 1; salt = 0;
        run_dump("len1029", 1029, 0);
        tgt_stall = 0;

        // byte 3 never acknowledged
        ack_dly = 0; miss = 3; salt = 8'h5A;
        run_dump("timeout", 20, 1);
        miss = -1;

        // zero length: done two cycles after start, no DDR traffic
        d0 = done_cnt;
        start_pulse(0);
        chk("len0_busy", busy, 1);
        chk("len0_done_early", done, 0);
        chk("len0_tmo_cleared", timeout_err, 0);
        tick();
        chk("len0_done", done, 1);
        chk("len0_busy_end", busy, 0);
        tick();
        chk("len0_done_pulse", done, 0);
        chk("len0_done_count", done_cnt - d0, 1);

        // second start while busy is ignored
        salt = 8'h33; ack_dly = 1;
        acc_cnt = 0; beat_in_burst = 0; burst_no = 0; last_key = -1;
        d0 = done_cnt;
        push_expected(24);
        start_pulse(24);
        tick(3);
        start_pulse(8);
        fin_dump("start_busy", 24, 0, d0);

        // boundary lengths
        for (int i = 0; i < 6; i++) begin
            ack_dly = 0; stall_pct = 10; salt = 8'(i * 37);
            run_dump($sformatf("bound%0d", bl[i]), bl[i], 0);
        end

        // randomized dumps
        for (int i = 0; i < 6; i++) begin
            int L = int'($urandom_range(1, 300));
            ack_dly   = int'($urandom_range(0, 3));
            stall_pct = int'($urandom_range(0, 40));
            salt      = int'($urandom_range(0, 255));
            miss      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            run_dump($sformatf("rand%0d", i), L, miss >= 0);
            miss = -1;
        end

        // reset in the middle of a burst
        stall_pct = 0; ack_dly = 0; salt = 0;
        acc_cnt = 0; beat_in_burst = 0; burst_no = 0; last_key = -1;
        push_expected(1024);
        start_pulse(1024);
        begin
            bit ok = 0;
            for (int i = 0; i < 20000; i++) begin
                tick();
                if (acc_cnt >= 40) begin ok = 1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL rst_mid_reach: got %0d beats expected 40", acc_cnt);
            end
        end
        rst = 1'b1;
        tick();
        chk("rst_mid_we", ddr.ddram_we, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        tick(3);
        chk("rst_mid_rd_req", rd_req, 0);
        chk("rst_mid_we_stays", ddr.ddram_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
